regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Integer register file at the receiving end of the commit-stage writeback interface (rd6 / wb_data6 / we6). It also supplies the two source operands to the issue stage. Write-through bypass lets a value being written back this cycle be read in the same cycle. A per-register pending-write scoreboard raises a stall when an issuing instruction needs a register whose producer has not yet written back.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers; x0 hardwired to zero
PEND_W, 2, width of each per-register pending-write counter (max 2^PEND_W-1 in flight per register)

Ports:
clk  input  1  clock
nrst  input  1  asynchronous active-low reset
we6  input  1  writeback enable from commit stage
rd6  input  5  writeback destination register
wb_data6  input  XLEN  writeback data
rs1  input  5  source register 1 address from decode
rs2  input  5  source register 2 address from decode
use_rs1  input  1  issuing instruction reads rs1
use_rs2  input  1  issuing instruction reads rs2
issue_valid  input  1  decode presents an instruction this cycle
issue_we  input  1  issuing instruction writes a destination
issue_rd  input  5  issuing instruction destination
sb_clear  input  1  synchronous flush of all pending counts (pipeline flush)
op_a  output  XLEN  operand for rs1
op_b  output  XLEN  operand for rs2
stall  output  1  issue must hold this cycle
issue_fire  output  1  instruction accepted (issue_valid && !stall)

Behaviour:
- Reset is asynchronous on nrst low: all registers = 0 and all pending counters = 0. After reset, op_a = op_b = 0, stall = 0 and issue_fire = 0 until issue_valid is asserted.
- Register write: at posedge clk, if we6 && rd6 != 0, then regs[rd6] <= wb_data6. Writes to x0 are ignored. Writeback is never back-pressured.
- Register read is combinational:
  - op_a = 0 if rs1 == 0.
  - Otherwise, if we6 && rd6 == rs1, op_a = wb_data6 (bypass).
  - Otherwise, op_a = regs[rs1].
  - op_b follows the same rule using rs2.
- Pending counter pend[r], r = 1..31, is PEND_W bits wide; pend[0] is always 0.
  - inc(r) when issue_fire && issue_we && issue_rd == r.
  - dec(r) when we6 && rd6 == r && pend[r] != 0.
  - If inc and dec hit the same r in one cycle, pend[r] is unchanged.
  - A writeback to a register with pend == 0 (e.g. after sb_clear) still updates the register; the counter stays 0 and never underflows.
  - sb_clear sets all counters to 0 at the next edge and overrides inc/dec in that cycle. The register write still occurs.
- Source hazard for rsX (rsX != 0, use_rsX = 1):
  - Hazard if pend[rsX] > 1.
  - Hazard if pend[rsX] == 1 and !(we6 && rd6 == rsX). A same-cycle writeback resolves the hazard via the bypass.
- Destination hazard: issue_we && issue_rd != 0 && pend[issue_rd] == max, with no dec on issue_rd this cycle (saturation guard).
- stall = issue_valid && (rs1 hazard || rs2 hazard || destination hazard). stall is combinational, with no added latency.
- issue_fire = issue_valid && !stall. Only a fired instruction increments a counter.
- sb_clear asserted together with issue_valid: stall is evaluated against the pre-clear counts, and an increment from a firing instruction is discarded.
- Read-to-operand latency is 0 cycles. Write-to-array latency is 1 cycle; the bypass covers that cycle.

Test Plan:
1. Reset, then read rs1 = 5, rs2 = 0 with no writes -> op_a = 0, op_b = 0, stall = 0.
2. we6 = 1, rd6 = 3, wb_data6 = 0xDEADBEEF, with rs1 = 3 in the same cycle -> op_a = 0xDEADBEEF via bypass. In the next cycle with we6 = 0 -> op_a = 0xDEADBEEF read from the array.
3. Write rd6 = 0, data 0x1234 -> reading rs1 = 0 returns 0, and no counter changes.
4. Issue with issue_rd = 7 fires, pend[7] = 1. Next cycle, issue with rs1 = 7, use_rs1 = 1 -> stall = 1. Writeback rd6 = 7, data 0x55 arrives -> same cycle stall = 0, op_a = 0x55, pend[7] = 0.
5. Fire 3 issues with issue_rd = 9 -> pend[9] = 3. A 4th issue to rd 9 stalls. One writeback to 9 in the same cycle as that 4th issue -> it fires and pend[9] stays 3. Reading rs2 = 9 with pend 3 -> stall.
6. pend[4] = 2, then sb_clear = 1 -> next cycle pend[4] = 0 and a read of rs1 = 4 does not stall. A later writeback to 4 with data 0xA -> register updated, counter stays 0. Assert nrst mid-stall -> stall = 0 and all registers read 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and a per-register
// pending-write scoreboard that stalls issue on unresolved producers.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            we6,
  input  logic [4:0]      rd6,
  input  logic [XLEN-1:0] wb_data6,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_rd,
  input  logic            sb_clear,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            issue_fire
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];

  logic haz_rs1, haz_rs2, haz_rd;

  // Operand read: x0 is zero, a same-cycle writeback wins over the array.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (rs1 != 5'd0) op_a = (we6 && rd6 == rs1) ? wb_data6 : regs_q[rs1];
    if (rs2 != 5'd0) op_b = (we6 && rd6 == rs2) ? wb_data6 : regs_q[rs2];
  end

  // A single outstanding producer is resolved by a writeback arriving now.
  always_comb begin
    haz_rs1 = use_rs1 && rs1 != 5'd0 &&
              (pend_q[rs1] > PEND_ONE ||
               (pend_q[rs1] == PEND_ONE && !(we6 && rd6 == rs1)));
    haz_rs2 = use_rs2 && rs2 != 5'd0 &&
              (pend_q[rs2] > PEND_ONE ||
               (pend_q[rs2] == PEND_ONE && !(we6 && rd6 == rs2)));
    haz_rd  = issue_we && issue_rd != 5'd0 && pend_q[issue_rd] == PEND_MAX &&
              !(we6 && rd6 == issue_rd);
    stall      = issue_valid && (haz_rs1 || haz_rs2 || haz_rd);
    issue_fire = issue_valid && !stall;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin : g_pend
      logic inc, dec;
      // NOTE: every combinational output gets a default before any branch,
      // otherwise a path that skips the assignment infers a latch.
      inc       = issue_fire && issue_we && issue_rd == 5'(r);
      dec       = we6 && rd6 == 5'(r) && pend_q[r] != '0;
      pend_d[r] = pend_q[r];
      if (sb_clear || r == 0)   pend_d[r] = '0;
      else if (inc && !dec)     pend_d[r] = pend_q[r] + PEND_ONE;
      else if (dec && !inc)     pend_d[r] = pend_q[r] - PEND_ONE;
    end
  end

  // NOTE: the array is reset because architectural state must read zero after
  // nrst; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (we6 && rd6 != 5'd0) regs_q[rd6] <= wb_data6;
      for (int r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run against an array-based model of the register/scoreboard rules.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        nrst;
  logic        we6;
  logic [4:0]  rd6;
  logic [31:0] wb_data6;
  logic [4:0]  rs1, rs2;
  logic        use_rs1, use_rs2;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd;
  logic        sb_clear;
  logic [31:0] op_a, op_b;
  logic        stall, issue_fire;

  int checks   = 0;
  int failures = 0;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .PEND_W(2)) dut (
    .clk(clk), .nrst(nrst), .we6(we6), .rd6(rd6), .wb_data6(wb_data6),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .sb_clear(sb_clear), .op_a(op_a), .op_b(op_b), .stall(stall),
    .issue_fire(issue_fire)
  );

  always #5 clk = ~clk;

  // Reference model: architectural values and count of in-flight writers.
  logic [31:0] m_regs [32];
  int          m_pend [32];

  task automatic idle();
    we6 = 0; rd6 = 0; wb_data6 = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0;
    issue_valid = 0; issue_we = 0; issue_rd = 0; sb_clear = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_op(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we6 && rd6 == a) return wb_data6;
    return m_regs[a];
  endfunction

  function automatic bit m_src_haz(input logic [4:0] a, input logic u);
    if (!u || a == 0) return 1'b0;
    if (m_pend[a] >= 2) return 1'b1;
    if (m_pend[a] == 1) return !(we6 && rd6 == a);
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    bit dest;
    dest = issue_we && issue_rd != 0 && m_pend[issue_rd] == 3 && !(we6 && rd6 == issue_rd);
    return issue_valid && (m_src_haz(rs1, use_rs1) || m_src_haz(rs2, use_rs2) || dest);
  endfunction

  task automatic m_update(input bit fired);
    if (we6 && rd6 != 0) m_regs[rd6] = wb_data6;
    if (sb_clear) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      if (we6 && rd6 != 0 && m_pend[rd6] > 0) m_pend[rd6]--;
      if (fired && issue_we && issue_rd != 0) m_pend[issue_rd]++;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'h0;
      m_pend[r] = 0;
    end
  endtask

  task automatic test_reset();
    idle(); rs1 = 5; rs2 = 0; #1;
    checks++; if (op_a !== 32'h0) begin failures++; $display("FAIL reset_op_a got=%h exp=0", op_a); end
    checks++; if (op_b !== 32'h0) begin failures++; $display("FAIL reset_op_b got=%h exp=0", op_b); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (issue_fire !== 1'b0) begin failures++; $display("FAIL reset_fire got=%b exp=0", issue_fire); end
    issue_valid = 1; use_rs1 = 1; #1;
    checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL reset_issue_fire got=%b exp=1", issue_fire); end
    tick();
  endtask

  task automatic test_bypass();
    idle(); we6 = 1; rd6 = 3; wb_data6 = 32'hDEADBEEF; rs1 = 3; rs2 = 3; #1;
    checks++; if (op_a !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_op_a got=%h exp=deadbeef", op_a); end
    checks++; if (op_b !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_op_b got=%h exp=deadbeef", op_b); end
    tick();
    idle(); rs1 = 3; #1;
    checks++; if (op_a !== 32'hDEADBEEF) begin failures++; $display("FAIL array_op_a got=%h exp=deadbeef", op_a); end
    tick();
  endtask

  task automatic test_x0();
    idle(); we6 = 1; rd6 = 0; wb_data6 = 32'h1234; rs1 = 0; #1;
    checks++; if (op_a !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", op_a); end
    tick();
    idle(); rs1 = 0; issue_valid = 1; use_rs1 = 1; #1;
    checks++; if (op_a !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", op_a); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_raw_hazard();
    idle(); issue_valid = 1; issue_we = 1; issue_rd = 7; #1;
    checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL raw_first_fire got=%b exp=1", issue_fire); end
    tick();
    idle(); issue_valid = 1; rs1 = 7; use_rs1 = 1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", stall); end
    checks++; if (issue_fire !== 1'b0) begin failures++; $display("FAIL raw_fire_blocked got=%b exp=0", issue_fire); end
    use_rs1 = 0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_unused_src got=%b exp=0", stall); end
    use_rs1 = 1; we6 = 1; rd6 = 7; wb_data6 = 32'h55; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_wb_resolves got=%b exp=0", stall); end
    checks++; if (op_a !== 32'h55) begin failures++; $display("FAIL raw_op_a got=%h exp=55", op_a); end
    tick();
    idle(); issue_valid = 1; rs1 = 7; use_rs1 = 1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_after_wb got=%b exp=0", stall); end
    checks++; if (op_a !== 32'h55) begin failures++; $display("FAIL raw_array got=%h exp=55", op_a); end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid = 1; issue_we = 1; issue_rd = 9; #1;
      checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL sat_fire_%0d got=%b exp=1", i, issue_fire); end
      tick();
    end
    idle(); issue_valid = 1; issue_we = 1; issue_rd = 9; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_dest_stall got=%b exp=1", stall); end
    we6 = 1; rd6 = 9; wb_data6 = 32'h99; #1;
    checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL sat_fire_with_wb got=%b exp=1", issue_fire); end
    tick();
    idle(); issue_valid = 1; rs2 = 9; use_rs2 = 1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_src_stall got=%b exp=1", stall); end
    we6 = 1; rd6 = 9; wb_data6 = 32'h9A; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_src_stall_wb got=%b exp=1", stall); end
    we6 = 0; tick();
  endtask

  task automatic test_clear_and_reset();
    for (int i = 0; i < 2; i++) begin
      idle(); issue_valid = 1; issue_we = 1; issue_rd = 4; #1;
      tick();
    end
    idle(); issue_valid = 1; rs1 = 4; use_rs1 = 1; we6 = 1; rd6 = 4; wb_data6 = 32'h77; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL pend2_wb_stall got=%b exp=1", stall); end
    tick();
    idle(); issue_valid = 1; rs1 = 4; use_rs1 = 1; sb_clear = 1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL clear_pre_count got=%b exp=1", stall); end
    tick();
    idle(); issue_valid = 1; rs1 = 4; use_rs1 = 1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL clear_no_stall got=%b exp=0", stall); end
    checks++; if (op_a !== 32'h77) begin failures++; $display("FAIL clear_op_a got=%h exp=77", op_a); end
    tick();
    idle(); issue_valid = 1; issue_we = 1; issue_rd = 10; sb_clear = 1; #1;
    checks++; if (issue_fire !== 1'b1) begin failures++; $display("FAIL clear_fire got=%b exp=1", issue_fire); end
    tick();
    idle(); issue_valid = 1; rs1 = 10; use_rs1 = 1; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL clear_inc_dropped got=%b exp=0", stall); end
    tick();
    idle(); we6 = 1; rd6 = 4; wb_data6 = 32'hA; #1;
    tick();
    idle(); issue_valid = 1; rs1 = 4; use_rs1 = 1; #1;
    checks++; if (op_a !== 32'hA) begin failures++; $display("FAIL wb_pend0_op_a got=%h exp=a", op_a); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wb_pend0_stall got=%b exp=0", stall); end
    tick();
    idle(); issue_valid = 1; issue_we = 1; issue_rd = 12; #1;
    tick();
    idle(); issue_valid = 1; rs1 = 12; use_rs1 = 1; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
    nrst = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", stall); end
    rs1 = 4; rs2 = 3; use_rs2 = 1; #1;
    checks++; if (op_a !== 32'h0) begin failures++; $display("FAIL midreset_op_a got=%h exp=0", op_a); end
    checks++; if (op_b !== 32'h0) begin failures++; $display("FAIL midreset_op_b got=%h exp=0", op_b); end
    #2 nrst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb;
    bit es, ef;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      we6         = 1'($urandom_range(0, 1));
      rd6         = 5'($urandom_range(0, 7));
      wb_data6    = $urandom;
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      use_rs1     = 1'($urandom_range(0, 1));
      use_rs2     = 1'($urandom_range(0, 1));
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_we    = ($urandom_range(0, 3) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      sb_clear    = ($urandom_range(0, 31) == 0);
      #1;
      ea = m_op(rs1);
      eb = m_op(rs2);
      es = m_stall();
      ef = issue_valid && !es;
      checks++; if (op_a !== ea) begin failures++; $display("FAIL rnd_op_a[%0d] got=%h exp=%h", n, op_a, ea); end
      checks++; if (op_b !== eb) begin failures++; $display("FAIL rnd_op_b[%0d] got=%h exp=%h", n, op_b, eb); end
      checks++; if (stall !== es) begin failures++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, stall, es); end
      checks++; if (issue_fire !== ef) begin failures++; $display("FAIL rnd_fire[%0d] got=%b exp=%b", n, issue_fire, ef); end
      @(posedge clk);
      m_update(ef);
      #1;
    end
    idle();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_bypass();
    test_x0();
    test_raw_hazard();
    test_saturation();
    test_clear_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
